// File: rtl/pcpi_serial_bridge.sv
// Segment-serial host front end for a PCPI coprocessor: gathers an instruction over a
// four-phase strobe/ack link, issues it with a timeout guard, and streams the result back.
module pcpi_serial_bridge #(
    parameter int unsigned SEG_W   = 4,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEG_W-1:0]  seg_in,
    input  logic              seg_strobe,
    output logic              seg_ack,
    output logic [SEG_W-1:0]  res_seg,
    output logic              res_valid,
    input  logic              res_take,
    output logic              busy,
    output logic              err_timeout,
    output logic              pcpi_valid,
    output logic [WORD_W-1:0] pcpi_insn,
    input  logic              pcpi_ready,
    input  logic              pcpi_wr,
    input  logic              pcpi_wait,
    input  logic [WORD_W-1:0] pcpi_rd
);

    localparam int unsigned NSEG      = WORD_W / SEG_W;
    localparam int unsigned SEG_CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int unsigned TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SEG_CNT_W-1:0] SEG_LAST = SEG_CNT_W'(NSEG - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t                state;
    logic [SEG_CNT_W-1:0]  seg_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [WORD_W-1:0]     result;

    // Handshake, issue and readback sequencing; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            seg_cnt     <= '0;
            tmo_cnt     <= '0;
            seg_ack     <= 1'b0;
            pcpi_valid  <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            pcpi_insn   <= '0;
            result      <= '0;
            res_seg     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (seg_strobe) begin
                        for (int i = 0; i < NSEG; i++) begin
                            if (seg_cnt == SEG_CNT_W'(i))
                                pcpi_insn[i*SEG_W +: SEG_W] <= seg_in;
                        end
                        if (seg_cnt == '0)
                            err_timeout <= 1'b0;
                        seg_ack <= 1'b1;
                        state   <= S_ACK;
                    end
                end

                // Wait for the strobe to fall so one strobe cycle yields one segment.
                S_ACK: begin
                    if (!seg_strobe) begin
                        seg_ack <= 1'b0;
                        if (seg_cnt == SEG_LAST) begin
                            seg_cnt    <= '0;
                            tmo_cnt    <= '0;
                            pcpi_valid <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_WAIT;
                        end else begin
                            seg_cnt <= seg_cnt + SEG_CNT_W'(1);
                            state   <= S_IDLE;
                        end
                    end
                end

                // Completion beats the timeout when both land on the same cycle.
                S_WAIT: begin
                    if (pcpi_ready) begin
                        pcpi_valid <= 1'b0;
                        if (pcpi_wr) begin
                            result    <= pcpi_rd;
                            res_seg   <= pcpi_rd[SEG_W-1:0];
                            seg_cnt   <= '0;
                            res_valid <= 1'b1;
                            state     <= S_RESULT;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (pcpi_wait) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        pcpi_valid  <= 1'b0;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_RESULT: begin
                    if (res_take) begin
                        if (seg_cnt == SEG_LAST) begin
                            res_valid <= 1'b0;
                            seg_cnt   <= '0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            seg_cnt <= seg_cnt + SEG_CNT_W'(1);
                            for (int i = 0; i < NSEG; i++) begin
                                if (seg_cnt + SEG_CNT_W'(1) == SEG_CNT_W'(i))
                                    res_seg <= result[i*SEG_W +: SEG_W];
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pcpi_serial_bridge.md
Name: pcpi_serial_bridge

Overview:
Parametrised successor to the nibble-serial PCPI front end. It assembles a WORD_W-bit instruction from SEG_W-bit segments delivered over a four-phase strobe/ack handshake, then issues it to a PCPI coprocessor and holds pcpi_valid until pcpi_ready. It adds a timeout with a sticky error flag, and returns the pcpi_rd result to the pin-limited host as SEG_W-bit segments. It sits between the top-level pin wrapper and the PCPI unit.

Parameters:
SEG_W, 4, segment width in bits; WORD_W must be a multiple of SEG_W.
WORD_W, 32, instruction and result width.
TIMEOUT, 16, number of consecutive idle WAIT cycles (pcpi_ready=0 and pcpi_wait=0) before the command is aborted; must be at least 1.
NSEG (localparam), WORD_W/SEG_W, number of segments per word.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
seg_in  in  SEG_W  instruction segment from the host.
seg_strobe  in  1  host asserts while seg_in is valid (four-phase).
seg_ack  out  1  segment-captured acknowledge.
res_seg  out  SEG_W  current result segment.
res_valid  out  1  res_seg is valid.
res_take  in  1  one-cycle pulse from the host: current segment consumed.
busy  out  1  high in WAIT or RESULT.
err_timeout  out  1  sticky: last command timed out.
pcpi_valid  out  1  PCPI request.
pcpi_insn  out  WORD_W  assembled instruction.
pcpi_ready  in  1  PCPI done.
pcpi_wr  in  1  PCPI result is valid (sampled together with pcpi_ready).
pcpi_wait  in  1  PCPI busy; suppresses the timeout.
pcpi_rd  in  WORD_W  PCPI result.

Behaviour:
- Reset (rst_n=0 at a clk edge, takes priority over everything, including mid-operation): state=IDLE; seg_cnt=0; tmo_cnt=0. Outputs seg_ack=0, pcpi_valid=0, res_valid=0, busy=0, err_timeout=0. pcpi_insn, the result register and res_seg are cleared to 0.
- States: IDLE, ACK, WAIT, RESULT.
- IDLE, seg_strobe=1: write seg_in into pcpi_insn[SEG_W*seg_cnt +: SEG_W] (LSB segment first). Set seg_ack<=1 and go to ACK. If seg_cnt==0, also clear err_timeout.
- ACK: seg_ack stays 1 while seg_strobe=1. When seg_strobe=0: seg_ack<=0.
  - If seg_cnt==NSEG-1: seg_cnt<=0, pcpi_valid<=1, tmo_cnt<=0, go to WAIT.
  - Otherwise: seg_cnt++, go to IDLE.
- Capture is one segment per full strobe cycle. A strobe held high never writes a second segment.
- seg_strobe is ignored in WAIT and RESULT: no ack is given and pcpi_insn is unchanged.
- WAIT: pcpi_valid=1 and pcpi_insn is stable.
  - pcpi_ready=1: pcpi_valid<=0. If pcpi_wr=1, latch pcpi_rd, seg_cnt<=0, res_valid<=1, go to RESULT. Otherwise go to IDLE.
  - Otherwise, if pcpi_wait=1: tmo_cnt<=0.
  - Otherwise: tmo_cnt++. When tmo_cnt reaches TIMEOUT-1 and the cycle is still idle: pcpi_valid<=0, err_timeout<=1, go to IDLE. This means pcpi_valid drops after exactly TIMEOUT idle cycles.
  - pcpi_ready wins over a timeout in the same cycle.
- RESULT: res_seg = result[SEG_W*seg_cnt +: SEG_W] (registered selection, valid while res_valid=1).
  - res_take=1 with seg_cnt<NSEG-1: seg_cnt++. The new segment is visible on the next cycle.
  - res_take=1 with seg_cnt==NSEG-1: res_valid<=0, seg_cnt<=0, go to IDLE.
  - res_take while res_valid=0 is ignored.
- busy = (state==WAIT) or (state==RESULT).
- Latency: pcpi_valid rises 1 cycle after the final seg_strobe falls. res_valid rises 1 cycle after the pcpi_ready cycle.
- Widths: seg_cnt and tmo_cnt are sized with $clog2 (minimum 1 bit). seg_cnt never wraps past NSEG-1.

Test Plan:
1. Reset mid-WAIT: send 8 segments, hold pcpi_ready=0 and pcpi_wait=1, pulse rst_n=0 for 1 cycle -> all outputs 0, state IDLE. A fresh 8-segment send then works.
2. Send segments 0x3,0x2,0x1,0x0,0xF,0xE,0xD,0xC, then pcpi_ready=1, pcpi_wr=0 at the 3rd WAIT cycle -> pcpi_insn=0xCDEF0123. pcpi_valid is high for exactly 3 cycles, then IDLE with res_valid=0.
3. Instruction as in test 2, then pcpi_ready=1, pcpi_wr=1, pcpi_rd=0xA5B6C7D8 -> res_valid=1. res_seg reads 0x8,0xD,0x7,0xC,0x6,0xB,0x5,0xA across 8 res_take pulses, then res_valid=0 and busy=0.
4. Timeout: 8 segments sent, then pcpi_ready=0, pcpi_wait=0 -> pcpi_valid drops after 16 cycles and err_timeout=1. err_timeout stays 1 until the next first segment is captured. If pcpi_wait=1 is asserted at cycle 10 of the idle run, no timeout occurs.
5. Strobe abuse: hold seg_strobe=1 for 5 cycles with seg_in changing -> exactly one segment written (the first value), seg_ack high until seg_strobe falls. seg_strobe pulsed during WAIT -> seg_ack stays 0 and pcpi_insn is unchanged.
6. Corner: pcpi_ready=1 in the same cycle tmo_cnt hits its limit -> normal completion, err_timeout=0. Rerun scenarios 2-3 with SEG_W=8, WORD_W=16: NSEG=2, segment ordering is LSB-first.
